// File: rtl/billiard_input_pkg.sv
// Shared types and constants for the billiard player-input front end:
// strike FSM states, keypad codes and default timing parameters.
package billiard_input_pkg;

    typedef enum logic [2:0] {
        S_WAIT,
        S_AIM,
        S_CHARGE,
        S_FIRE,
        S_MOVING,
        S_SETTLE
    } strike_state_t;

    localparam logic [3:0] KEY_CANCEL = 4'd0;
    localparam logic [3:0] KEY_EASY   = 4'd1;
    localparam logic [3:0] KEY_MEDIUM = 4'd2;
    localparam logic [3:0] KEY_HARD   = 4'd3;
    localparam logic [3:0] KEY_ROT_L  = 4'd4;
    localparam logic [3:0] KEY_FIRE   = 4'd5;
    localparam logic [3:0] KEY_ROT_R  = 4'd6;

    localparam int DEF_ANGLE_STEPS   = 32;
    localparam int DEF_POWER_MAX     = 15;
    localparam int DEF_CHARGE_FRAMES = 4;
    localparam int DEF_ROTATE_FRAMES = 2;
    localparam int DEF_SETTLE_FRAMES = 8;

    function automatic logic isLevelKey(input logic [3:0] code);
        return (code == KEY_EASY) || (code == KEY_MEDIUM) || (code == KEY_HARD);
    endfunction

    function automatic logic isRotateKey(input logic [3:0] code);
        return (code == KEY_ROT_L) || (code == KEY_ROT_R);
    endfunction

endpackage

// File: rtl/frame_tick_divider.sv
// Counts video-frame pulses and emits a one-cycle tick on every N-th one;
// 'clear' restarts the count so each hold/charge/settle period starts fresh.
module frame_tick_divider #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic startOfFrame,
    output logic tick
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] r_count;
    logic          w_lastFrame;

    assign w_lastFrame = (r_count == CW'(N - 1));

    // The tick is combinational so the consumer acts on the very frame pulse that completes the period.
    assign tick = startOfFrame & ~clear & w_lastFrame;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (startOfFrame) begin
            if (w_lastFrame) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cue_strike_controller.sv
// Keypad front end: turns raw key events into the menu level selection and
// the aim/charge/strike handshake consumed by the game controller and physics.
module cue_strike_controller
    import billiard_input_pkg::*;
#(
    parameter int ANGLE_STEPS   = DEF_ANGLE_STEPS,
    parameter int POWER_MAX     = DEF_POWER_MAX,
    parameter int CHARGE_FRAMES = DEF_CHARGE_FRAMES,
    parameter int ROTATE_FRAMES = DEF_ROTATE_FRAMES,
    parameter int SETTLE_FRAMES = DEF_SETTLE_FRAMES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       menu_state,
    input  logic       game_state,
    input  logic       no_moving_flag,
    output logic [3:0] level,
    output logic       level_is_valid,
    output logic       strike,
    output logic [4:0] strike_angle,
    output logic [3:0] strike_power,
    output logic       aim_visible,
    output logic       charging
);

    logic          r_keyValidD;
    logic [3:0]    r_codeD;
    logic [3:0]    r_level;
    logic          r_levelValid;
    strike_state_t r_state;
    logic          r_strike;
    logic [4:0]    r_angle;
    logic [3:0]    r_power;
    logic          r_aimVisible;
    logic          r_charging;

    logic w_press;
    logic w_release;
    logic w_rotClear;
    logic w_chargeClear;
    logic w_settleClear;
    logic w_rotTick;
    logic w_chargeTick;
    logic w_settleTick;

    // A code change while the key stays down is neither a press nor a release.
    assign w_press   = key_valid & ~r_keyValidD;
    assign w_release = ~key_valid & r_keyValidD;

    assign w_rotClear    = ~((r_state == S_AIM) && key_valid && isRotateKey(key_code));
    assign w_chargeClear = (r_state != S_CHARGE);
    assign w_settleClear = (r_state != S_MOVING);

    frame_tick_divider #(.N(ROTATE_FRAMES)) u_rotateDiv (
        .clk          (clk),
        .reset        (reset),
        .clear        (w_rotClear),
        .startOfFrame (startOfFrame),
        .tick         (w_rotTick)
    );

    frame_tick_divider #(.N(CHARGE_FRAMES)) u_chargeDiv (
        .clk          (clk),
        .reset        (reset),
        .clear        (w_chargeClear),
        .startOfFrame (startOfFrame),
        .tick         (w_chargeTick)
    );

    frame_tick_divider #(.N(SETTLE_FRAMES)) u_settleDiv (
        .clk          (clk),
        .reset        (reset),
        .clear        (w_settleClear),
        .startOfFrame (startOfFrame),
        .tick         (w_settleTick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_keyValidD <= 1'b0;
            r_codeD     <= '0;
        end else begin
            r_keyValidD <= key_valid;
            r_codeD     <= key_code;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_level      <= '0;
            r_levelValid <= 1'b0;
        end else begin
            r_levelValid <= 1'b0;
            if (menu_state && w_press && isLevelKey(key_code)) begin
                r_level      <= key_code;
                r_levelValid <= 1'b1;
            end
        end
    end

    // Leaving play wins over everything, including a fire release in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_WAIT;
            r_strike     <= 1'b0;
            r_angle      <= '0;
            r_power      <= '0;
            r_aimVisible <= 1'b0;
            r_charging   <= 1'b0;
        end else begin
            r_strike <= 1'b0;
            if (!game_state) begin
                r_state      <= S_WAIT;
                r_power      <= '0;
                r_aimVisible <= 1'b0;
                r_charging   <= 1'b0;
            end else begin
                case (r_state)
                    S_WAIT: begin
                        if (no_moving_flag) begin
                            r_state      <= S_AIM;
                            r_aimVisible <= 1'b1;
                        end
                    end
                    S_AIM: begin
                        if (w_press && (key_code == KEY_FIRE)) begin
                            r_state    <= S_CHARGE;
                            r_power    <= '0;
                            r_charging <= 1'b1;
                        end else if (w_rotTick) begin
                            if (key_code == KEY_ROT_L) begin
                                r_angle <= (r_angle == '0) ? 5'(ANGLE_STEPS - 1) : r_angle - 5'd1;
                            end else begin
                                r_angle <= (r_angle == 5'(ANGLE_STEPS - 1)) ? '0 : r_angle + 5'd1;
                            end
                        end
                    end
                    S_CHARGE: begin
                        if (w_press && (key_code == KEY_CANCEL)) begin
                            r_state    <= S_AIM;
                            r_power    <= '0;
                            r_charging <= 1'b0;
                        end else if (w_release && (r_codeD == KEY_FIRE)) begin
                            r_charging <= 1'b0;
                            if (r_power != '0) begin
                                r_state      <= S_FIRE;
                                r_strike     <= 1'b1;
                                r_aimVisible <= 1'b0;
                            end else begin
                                r_state <= S_AIM;
                            end
                        end else if (w_chargeTick && (r_power != 4'(POWER_MAX))) begin
                            r_power <= r_power + 4'd1;
                        end
                    end
                    S_FIRE: begin
                        r_state <= S_MOVING;
                    end
                    S_MOVING: begin
                        if (!no_moving_flag) begin
                            r_state <= S_SETTLE;
                        end else if (w_settleTick) begin
                            r_state      <= S_AIM;
                            r_aimVisible <= 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        if (no_moving_flag) begin
                            r_state      <= S_AIM;
                            r_aimVisible <= 1'b1;
                        end
                    end
                    default: begin
                        r_state      <= S_WAIT;
                        r_aimVisible <= 1'b0;
                        r_charging   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign level          = r_level;
    assign level_is_valid = r_levelValid;
    assign strike         = r_strike;
    assign strike_angle   = r_angle;
    assign strike_power   = r_power;
    assign aim_visible    = r_aimVisible;
    assign charging       = r_charging;

endmodule
